sort4_ctrl: RTL and testbench

SORT4_CTRL -- requirements
Module: sort4_ctrl

---
 rtl/sort4_ctrl_pkg.sv | 21 ++
 rtl/sort4_ctrl_cmp.sv | 25 ++
 rtl/sort4_ctrl.sv | 151 +++++++++++++++
 tb/tb_sort4_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sort4_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sort4_ctrl_pkg
//  Description : Shared types and constants for the four-element sorter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sort4_ctrl_pkg;

    localparam int W          = 4;   // element width in bits
    localparam int N          = 4;   // element count (fixed)
    localparam int MAX_PASS   = 2;   // last pass index of the bubble sort
    localparam int SWAP_CNT_W = 3;   // holds 0..6 swaps

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : sort4_ctrl_pkg
`default_nettype wire

// File: rtl/sort4_ctrl_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : sort4_ctrl_cmp
//  Description : Unsigned magnitude comparator producing eq / lt / gt flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module sort4_ctrl_cmp #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         ceq,
    output logic         clt,
    output logic         cgt
);

    // Exactly one of the three flags is high for any operand pair.
    always_comb begin
        ceq = (i_a == i_b);
        clt = (i_a <  i_b);
        cgt = (i_a >  i_b);
    end

endmodule : sort4_ctrl_cmp
`default_nettype wire

// File: rtl/sort4_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sort4_ctrl
//  Description : Sequential bubble sort of four W-bit elements, one compare
//                per cycle through a single shared comparator, with early
//                exit when a pass makes no swap.
//  Revision    : 1.0 - initial release
// ============================================================================
module sort4_ctrl #(
    parameter int W = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  dir,
    input  logic [4*W-1:0]                        din,
    output logic                                  busy,
    output logic                                  done,
    output logic [4*W-1:0]                        dout,
    output logic [sort4_ctrl_pkg::SWAP_CNT_W-1:0] swap_count
);

    import sort4_ctrl_pkg::*;

    localparam logic [1:0] LAST_PASS = 2'(MAX_PASS);

    state_t                  r_state;
    logic [W-1:0]            r_d [N];
    logic                    r_dir;
    logic [1:0]              r_pass;
    logic [1:0]              r_idx;
    logic                    r_flag;
    logic [SWAP_CNT_W-1:0]   r_swaps;

    logic [1:0]              w_idx_p1;
    logic [W-1:0]            w_a;
    logic [W-1:0]            w_b;
    logic                    w_ceq;
    logic                    w_clt;
    logic                    w_cgt;
    logic                    w_swap;
    logic                    w_last;
    logic                    w_flag_nxt;
    logic                    w_finish;
    logic [SWAP_CNT_W-1:0]   w_cnt_nxt;
    logic [W-1:0]            w_d_nxt [N];
    logic [4*W-1:0]          w_pack;

    // Select the adjacent pair addressed by idx for the shared comparator.
    always_comb begin
        w_idx_p1 = r_idx + 2'd1;
        w_a      = r_d[r_idx];
        w_b      = r_d[w_idx_p1];
    end

    sort4_ctrl_cmp #(
        .W   (W)
    ) u_cmp (
        .i_a (w_a),
        .i_b (w_b),
        .ceq (w_ceq),
        .clt (w_clt),
        .cgt (w_cgt)
    );

    // Swap decision, post-compare element array and pass/exit bookkeeping.
    always_comb begin
        w_swap     = ~w_ceq & (r_dir ? w_clt : w_cgt);
        w_flag_nxt = r_flag | w_swap;
        w_cnt_nxt  = r_swaps + SWAP_CNT_W'(w_swap);
        w_last     = (r_idx == (LAST_PASS - r_pass));
        w_finish   = w_last & ((r_pass == LAST_PASS) | ~w_flag_nxt);
        for (int i = 0; i < N; i++) begin
            w_d_nxt[i] = r_d[i];
        end
        if (w_swap) begin
            w_d_nxt[r_idx]    = w_b;
            w_d_nxt[w_idx_p1] = w_a;
        end
        w_pack = '0;
        for (int i = 0; i < N; i++) begin
            w_pack[i*W +: W] = w_d_nxt[i];
        end
    end

    // Control FSM with registered busy/done and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            for (int i = 0; i < N; i++) begin
                r_d[i] <= '0;
            end
            r_dir      <= 1'b0;
            r_pass     <= 2'd0;
            r_idx      <= 2'd0;
            r_flag     <= 1'b0;
            r_swaps    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dout       <= '0;
            swap_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            r_d[i] <= din[i*W +: W];
                        end
                        r_dir   <= dir;
                        r_pass  <= 2'd0;
                        r_idx   <= 2'd0;
                        r_flag  <= 1'b0;
                        r_swaps <= '0;
                        busy    <= 1'b1;
                        r_state <= CMP;
                    end
                end
                CMP: begin
                    r_d     <= w_d_nxt;
                    r_swaps <= w_cnt_nxt;
                    if (w_finish) begin
                        dout       <= w_pack;
                        swap_count <= w_cnt_nxt;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        r_state    <= DONE;
                    end else if (w_last) begin
                        r_pass <= r_pass + 2'd1;
                        r_idx  <= 2'd0;
                        r_flag <= 1'b0;
                    end else begin
                        r_idx  <= w_idx_p1;
                        r_flag <= w_flag_nxt;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : sort4_ctrl
`default_nettype wire

// File: tb/tb_sort4_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sort4_ctrl
//  Description : Scoreboard bench for sort4_ctrl: directed cases plus random
//                sorts against a behavioural bubble-sort model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sort4_ctrl;

    typedef struct {
        logic [15:0] dout;
        logic [2:0]  sc;
        int          c;
        int          k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [2:0]  swap_count;

    int          cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        q[$];
    exp_t        mon_e;
    logic [15:0] hold_dout = '0;
    logic [2:0]  hold_sc   = '0;
    int          busy_cnt  = 0;

    sort4_ctrl #(.W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dir        (dir),
        .din        (din),
        .busy       (busy),
        .done       (done),
        .dout       (dout),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: bubble sort with early exit, counting compares and swaps.
    task automatic model(input logic [15:0] d, input logic dsc,
                         output logic [15:0] res, output int sw, output int c);
        int a[4];
        int t;
        bit any;
        for (int i = 0; i < 4; i++) a[i] = int'(d[4*i +: 4]);
        sw = 0;
        c  = 0;
        for (int p = 0; p < 3; p++) begin
            any = 0;
            for (int j = 0; j <= 2 - p; j++) begin
                c++;
                if (dsc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                    sw++;
                    any = 1;
                end
            end
            if (!any) break;
        end
        for (int i = 0; i < 4; i++) res[4*i +: 4] = 4'(a[i]);
    endtask

    // Issue one sort, queue its expectation, scramble inputs while busy and
    // optionally pulse start on CMP cycle 'glitch'; return once done is seen.
    task automatic run(input logic [15:0] d, input logic dsc,
                       input logic [15:0] e_dout, input int e_sc, input int e_c,
                       input int glitch);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        start = 1'b1;
        din   = d;
        dir   = dsc;
        e.dout = e_dout;
        e.sc   = 3'(e_sc);
        e.c    = e_c;
        e.k    = cyc + 1;
        q.push_back(e);
        n    = 0;
        seen = 0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            start = 1'b0;
            din   = 16'($urandom);
            dir   = 1'($urandom);
            n++;
            if (done) seen = 1;
            else if (n == glitch) start = 1'b1;
        end
        start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_model(input logic [15:0] d, input logic dsc, input int glitch);
        logic [15:0] r;
        int sw;
        int c;
        model(d, dsc, r, sw, c);
        run(d, dsc, r, sw, c, glitch);
    endtask

    // Monitor: results hold while busy, and each done matches the queue head.
    always @(negedge clk) begin
        if (rst) begin
            hold_dout = '0;
            hold_sc   = '0;
            busy_cnt  = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
                check("dout_hold", 32'(dout), 32'(hold_dout));
                check("swap_count_hold", 32'(swap_count), 32'(hold_sc));
            end
            if (done) begin
                check("busy_low_at_done", 32'(busy), 32'd0);
                check("expectation_queued", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    check("dout", 32'(dout), 32'(mon_e.dout));
                    check("swap_count", 32'(swap_count), 32'(mon_e.sc));
                    check("done_latency", 32'(cyc), 32'(mon_e.k + mon_e.c));
                    check("busy_cycles", 32'(busy_cnt), 32'(mon_e.c));
                end
                hold_dout = dout;
                hold_sc   = swap_count;
                busy_cnt  = 0;
            end
        end
    end

    initial begin
        logic [15:0] d;
        rst   = 1'b1;
        start = 1'b0;
        dir   = 1'b0;
        din   = '0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        din   = 16'hFFFF;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_swap_count", 32'(swap_count), 32'd0);
        start = 1'b0;
        rst   = 1'b0;

        // Directed cases with literal expectations.
        run(16'h0F1D, 1'b0, 16'hFD10, 4, 6, 0);
        run(16'hDA44, 1'b0, 16'hDA44, 0, 3, 0);
        run(16'h4AD0, 1'b1, 16'h04AD, 3, 5, 0);
        run(16'h0ADF, 1'b0, 16'hFDA0, 6, 6, 3);

        // Reset during the second compare cycle aborts the sort.
        @(negedge clk);
        start = 1'b1;
        din   = 16'h0F1D;
        dir   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dout", 32'(dout), 32'd0);
        check("abort_swap_count", 32'(swap_count), 32'd0);
        rst = 1'b0;
        run(16'h0F1D, 1'b0, 16'hFD10, 4, 6, 0);

        // Random sorts, a third of them with many duplicate elements.
        for (int j = 0; j < 60; j++) begin
            if (j % 3 == 0) begin
                for (int i = 0; i < 4; i++) d[4*i +: 4] = 4'($urandom_range(0, 3));
            end else begin
                d = 16'($urandom);
            end
            run_model(d, 1'($urandom), $urandom_range(0, 4));
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sort4_ctrl
`default_nettype wire
